// File: rtl/seq_pkg.sv
// seq_pkg: opcode, state encoding and sizing constants shared by the sequencer.
package seq_pkg;

   localparam int unsigned OP_W         = 3;
   localparam int unsigned ST_W         = 3;
   localparam int unsigned CNT_W        = 8;
   localparam int unsigned WAIT_W       = 2;
   localparam int unsigned MEM_WAIT_MAX = 3;

   localparam logic [OP_W-1:0] OP_LDA = 3'b000;
   localparam logic [OP_W-1:0] OP_STA = 3'b001;
   localparam logic [OP_W-1:0] OP_ADD = 3'b010;
   localparam logic [OP_W-1:0] OP_SUB = 3'b011;
   localparam logic [OP_W-1:0] OP_AND = 3'b100;
   localparam logic [OP_W-1:0] OP_JMP = 3'b101;
   localparam logic [OP_W-1:0] OP_JZ  = 3'b110;
   localparam logic [OP_W-1:0] OP_JC  = 3'b111;

   typedef enum logic [ST_W-1:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_EXEC   = 3'd5,
      ST_HALT   = 3'd6
   } state_t;

   // Jumps skip the memory phase and resolve in EXEC.
   function automatic logic is_jump_op(input logic [OP_W-1:0] op);
      return (op == OP_JMP) || (op == OP_JZ) || (op == OP_JC);
   endfunction

endpackage

// File: rtl/seq_waitcnt.sv
// seq_waitcnt: 2-bit load/decrement RAM wait counter with a registered done flag.
module seq_waitcnt
   import seq_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              dec,
   input  logic [WAIT_W-1:0] load_val,
   output logic              done
);

   logic [WAIT_W-1:0] cnt, cnt_nxt;

   always_comb begin
      cnt_nxt = cnt;
      if (load)                  cnt_nxt = load_val;
      else if (dec && cnt != '0) cnt_nxt = cnt - WAIT_W'(1);
   end

   // done tracks cnt == 0 so it lines up with the counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         done <= 1'b1;
      end else begin
         cnt  <= cnt_nxt;
         done <= (cnt_nxt == '0);
      end
   end

endmodule

// File: rtl/seq_ctrl.sv
// seq_ctrl: Moore instruction sequencer for a small accumulator CPU.
// Single-step support from HALT is built only when SEQ_STEP_EN is defined.
module seq_ctrl
   import seq_pkg::*;
#(
   parameter int unsigned MEM_WAIT = 0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [OP_W-1:0]  op_i,
   input  logic             flag_z_i,
   input  logic             flag_c_i,
   input  logic             run_i,
   input  logic             halt_req_i,
   input  logic             step_i,
   output logic             ir_we_o,
   output logic             pc_inc_o,
   output logic             pc_load_o,
   output logic             ram_re_o,
   output logic             ram_we_o,
   output logic             ac_we_o,
   output logic             flag_we_o,
   output logic [OP_W-1:0]  alu_op_o,
   output logic [ST_W-1:0]  state_o,
   output logic             halted_o,
   output logic [CNT_W-1:0] insn_cnt_o
);

   localparam int unsigned WAIT_LD = (MEM_WAIT > MEM_WAIT_MAX) ? MEM_WAIT_MAX : MEM_WAIT;

   state_t           state, state_nxt;
   logic [OP_W-1:0]  opcode, opcode_nxt;
   logic [CNT_W-1:0] insn_cnt;
   logic             retire, resume, stop_on_retire;
   logic             wait_load, wait_dec, wait_done, take_branch;

`ifdef SEQ_STEP_EN
   logic step_mode;

   // step_mode marks an instruction launched by step_i; it always ends in HALT
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                          step_mode <= 1'b0;
      else if (state == ST_HALT && step_i)  step_mode <= 1'b1;
      else if (retire)                      step_mode <= 1'b0;
   end

   assign resume         = step_i | (run_i & ~halt_req_i);
   assign stop_on_retire = halt_req_i | step_mode;
`else
   logic unused_step;

   assign unused_step    = step_i;
   assign resume         = run_i & ~halt_req_i;
   assign stop_on_retire = halt_req_i;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state    <= ST_IDLE;
         opcode   <= '0;
         insn_cnt <= '0;
      end else begin
         state  <= state_nxt;
         opcode <= opcode_nxt;
         if (retire) insn_cnt <= insn_cnt + CNT_W'(1);
      end
   end

   always_comb begin
      take_branch = 1'b0;
      case (opcode)
         OP_JMP:  take_branch = 1'b1;
         OP_JZ:   take_branch = flag_z_i;
         OP_JC:   take_branch = flag_c_i;
         default: take_branch = 1'b0;
      endcase
   end

   // next state and Moore strobes
   always_comb begin
      state_nxt  = state;
      opcode_nxt = opcode;
      retire     = 1'b0;
      wait_load  = 1'b0;
      wait_dec   = 1'b0;
      ir_we_o    = 1'b0;
      pc_inc_o   = 1'b0;
      pc_load_o  = 1'b0;
      ram_re_o   = 1'b0;
      ram_we_o   = 1'b0;
      ac_we_o    = 1'b0;
      flag_we_o  = 1'b0;
      halted_o   = 1'b0;

      case (state)
         ST_IDLE: begin
            if (run_i) state_nxt = ST_FETCH;
         end
         ST_FETCH: begin
            ir_we_o   = 1'b1;
            pc_inc_o  = 1'b1;
            state_nxt = ST_DECODE;
         end
         ST_DECODE: begin
            opcode_nxt = op_i;
            wait_load  = 1'b1;
            state_nxt  = is_jump_op(op_i) ? ST_EXEC : ST_MEM;
         end
         ST_MEM: begin
            if (opcode == OP_STA) begin
               ram_we_o = 1'b1;
               retire   = 1'b1;
            end else begin
               ram_re_o = 1'b1;
               if (wait_done) state_nxt = ST_WB;
               else           wait_dec  = 1'b1;
            end
         end
         ST_WB: begin
            ac_we_o   = 1'b1;
            flag_we_o = 1'b1;
            retire    = 1'b1;
         end
         ST_EXEC: begin
            pc_load_o = take_branch;
            retire    = 1'b1;
         end
         ST_HALT: begin
            halted_o = 1'b1;
            if (resume) state_nxt = ST_FETCH;
         end
         default: state_nxt = ST_IDLE;
      endcase

      if (retire) state_nxt = stop_on_retire ? ST_HALT : ST_FETCH;
   end

   seq_waitcnt u_waitcnt (
      .clk      (clk_i),
      .rst_n    (rst_ni),
      .load     (wait_load),
      .dec      (wait_dec),
      .load_val (WAIT_W'(WAIT_LD)),
      .done     (wait_done)
   );

   assign alu_op_o   = opcode;
   assign state_o    = state;
   assign insn_cnt_o = insn_cnt;

endmodule
